fp_add_sequencer: RTL and testbench

- Initiator side of the FloatingPointAdder Go/Ready handshake.
- Accepts operand pairs on a valid/ready input stream and drives AddendA/AddendB/Go to the adder.
- Tracks the adder's Ready/Go sequence and captures Result plus the Zero/Inf/Nan flags into a small output FIFO with valid/ready.
- Sits between the system operand source and the adder. Also owns the adder's synchronous reset and a completion watchdog.

---
 rtl/floatingpointpkg.sv | 11 +
 rtl/fp_result_fifo.sv | 43 ++++
 rtl/fp_add_sequencer.sv | 97 +++++++++
 tb/tb_fp_add_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/floatingpointpkg.sv
// floatingpointpkg: shared float types, adder result record and sequencer states.
package floatingpointpkg;
   typedef logic [31:0] float;
   typedef struct packed {
      float res;
      logic zero;
      logic inf;
      logic nan;
   } fp_result_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE} seq_state_t;
endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: small FIFO of adder results; the head stays visible after draining.
module fp_result_fifo
   import floatingpointpkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   Clock,
   input  logic                   ResetN,
   input  logic                   Push,
   input  logic                   Pop,
   input  fp_result_t             PushData,
   output fp_result_t             Head,
   output logic                   Full,
   output logic                   Empty,
   output logic [$clog2(DEPTH):0] Count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fp_result_t mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr, prevPtr;
   logic doPop;
   assign Empty = Count == '0;
   assign Full = Count == CW'(DEPTH);
   assign doPop = Pop & ~Empty;
   assign prevPtr = rdPtr - AW'(1);
   // once drained, keep presenting the most recently popped entry
   assign Head = Empty ? mem[prevPtr] : mem[rdPtr];
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         Count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (Push) begin
            mem[wrPtr] <= PushData;
            wrPtr <= wrPtr + AW'(1);
         end
         if (doPop) rdPtr <= rdPtr + AW'(1);
         Count <= Count + CW'(Push) - CW'(doPop);
      end
   end
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: drives the FloatingPointAdder Go/Ready handshake one op at a time
// and queues results; owns the adder reset and a completion watchdog.
module fp_add_sequencer
   import floatingpointpkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TIMEOUT = 64
) (
   input  logic Clock,
   input  logic ResetN,
   input  logic InValid,
   output logic InReady,
   input  float InA,
   input  float InB,
   output float AddendA,
   output float AddendB,
   output logic Go,
   output logic AdderReset,
   input  logic AdderReady,
   input  float AdderResult,
   input  logic AdderZero,
   input  logic AdderInf,
   input  logic AdderNan,
   output logic OutValid,
   input  logic OutReady,
   output float OutResult,
   output logic OutZero,
   output logic OutInf,
   output logic OutNan,
   output logic Timeout
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   seq_state_t state, nextState;
   logic [1:0] resetSync;
   logic [WW-1:0] wdog;
   logic [CW-1:0] count;
   logic full, empty, push, pop, accept, expire;
   fp_result_t head;
   assign AdderReset = resetSync[1];
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) resetSync <= 2'b11;
      else resetSync <= {resetSync[0], 1'b0};
   end
   always_comb begin
      InReady = (state == IDLE) & ~AdderReset & (count < CW'(DEPTH));
      accept = InValid & InReady;
      Go = state == ISSUE;
      // only a Ready rising after WAIT_CLR saw it low belongs to this op
      push = (state == WAIT_DONE) & AdderReady;
      expire = ((state == WAIT_CLR) | (state == WAIT_DONE)) & ~push & (wdog == WW'(TIMEOUT - 1));
      nextState = state;
      unique case (state)
         IDLE:      nextState = accept ? ISSUE : IDLE;
         ISSUE:     nextState = WAIT_CLR;
         WAIT_CLR:  nextState = expire ? IDLE : (AdderReady ? WAIT_CLR : WAIT_DONE);
         WAIT_DONE: nextState = (push | expire) ? IDLE : WAIT_DONE;
      endcase
   end
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) state <= IDLE;
      else state <= nextState;
   end
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         AddendA <= '0;
         AddendB <= '0;
         wdog <= '0;
         Timeout <= 1'b0;
      end else begin
         if (accept) begin
            AddendA <= InA;
            AddendB <= InB;
         end
         wdog <= accept ? '0 : (state != IDLE ? wdog + WW'(1) : wdog);
         if (expire) Timeout <= 1'b1;
      end
   end
   assign pop = OutValid & OutReady;
   assign OutValid = ~empty;
   assign OutResult = head.res;
   assign OutZero = head.zero;
   assign OutInf = head.inf;
   assign OutNan = head.nan;
   fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clock(Clock),
      .ResetN(ResetN),
      .Push(push),
      .Pop(pop),
      .PushData('{res: AdderResult, zero: AdderZero, inf: AdderInf, nan: AdderNan}),
      .Head(head),
      .Full(full),
      .Empty(empty),
      .Count(count)
   );
   assert property (@(posedge Clock) disable iff (!ResetN) !(push && full));
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed checks of the sequencer against a behavioural adder stub.
module tb_fp_add_sequencer;
   logic Clock = 1'b0;
   logic ResetN = 1'b1;
   logic InValid = 1'b0, OutReady = 1'b0;
   logic [31:0] InA = '0, InB = '0;
   logic InReady, Go, AdderReset, OutValid, OutZero, OutInf, OutNan, Timeout;
   logic [31:0] AddendA, AddendB, OutResult;
   logic AdderZero, AdderInf, AdderNan;
   logic stubReady = 1'b0, stubSeen = 1'b0, stubDead = 1'b0;
   int stubCnt = 0;
   logic [31:0] stubRes = '0;
   int checks = 0, failures = 0;
   logic [31:0] bpA [6] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000, 32'h3F800000};
   logic [31:0] bpB [6] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000, 32'h40800000};
   logic [31:0] bpR [6] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h40A00000};

   always #5 Clock = ~Clock;

   fp_add_sequencer dut (
      .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
      .InA(InA), .InB(InB), .AddendA(AddendA), .AddendB(AddendB), .Go(Go),
      .AdderReset(AdderReset), .AdderReady(stubReady), .AdderResult(stubRes),
      .AdderZero(AdderZero), .AdderInf(AdderInf), .AdderNan(AdderNan),
      .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
      .OutZero(OutZero), .OutInf(OutInf), .OutNan(OutNan), .Timeout(Timeout)
   );

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h3F800000}: return 32'h40000000;
         {32'h3F800000, 32'hBF800000}: return 32'h00000000;
         {32'h3FC00000, 32'h40200000}: return 32'h40800000;
         {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         {32'h40000000, 32'h40800000}: return 32'h40C00000;
         {32'h40800000, 32'h40800000}: return 32'h41000000;
         {32'h3F800000, 32'h40800000}: return 32'h40A00000;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   // adder stub: Ready drops one cycle after Go is sampled, rises 3 cycles later
   assign AdderZero = stubRes == 32'h0;
   assign AdderInf = stubRes[30:0] == 31'h7F800000;
   assign AdderNan = (&stubRes[30:23]) && (|stubRes[22:0]);
   always @(posedge Clock) begin
      if (AdderReset) begin
         stubReady <= 1'b0;
         stubSeen <= 1'b0;
         stubCnt <= 0;
      end else begin
         stubSeen <= Go;
         if (stubSeen) begin
            stubReady <= 1'b0;
            stubCnt <= 3;
         end else if (stubCnt > 0) begin
            stubCnt <= stubCnt - 1;
            if (stubCnt == 1 && !stubDead) begin
               stubReady <= 1'b1;
               stubRes <= fadd(AddendA, AddendB);
            end
         end
      end
   end

   task automatic offer(input logic [31:0] a, input logic [31:0] b, output int waited);
      InValid = 1'b1;
      InA = a;
      InB = b;
      waited = 0;
      while (!InReady && waited < 200) begin
         @(negedge Clock);
         waited++;
      end
      @(posedge Clock);
      @(negedge Clock);
      InValid = 1'b0;
   endtask

   task automatic pop1;
      OutReady = 1'b1;
      @(negedge Clock);
      OutReady = 1'b0;
   endtask

   task automatic test_reset;
      #1 ResetN = 1'b0;
      @(negedge Clock);
      checks++; if (Go !== 1'b0) begin failures++; $display("FAIL reset_go got=%b exp=0", Go); end
      checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b exp=0", InReady); end
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
      checks++; if (Timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", Timeout); end
      checks++; if (AdderReset !== 1'b1) begin failures++; $display("FAIL reset_adderreset got=%b exp=1", AdderReset); end
      checks++; if (AddendA !== 32'h0) begin failures++; $display("FAIL reset_addenda got=%h exp=0", AddendA); end
      repeat (2) @(negedge Clock);
      ResetN = 1'b1;
      @(negedge Clock);
      checks++; if (AdderReset !== 1'b1) begin failures++; $display("FAIL reset_sync1 got=%b exp=1", AdderReset); end
      checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL reset_inready_sync got=%b exp=0", InReady); end
      @(negedge Clock);
      checks++; if (AdderReset !== 1'b0) begin failures++; $display("FAIL reset_sync2 got=%b exp=0", AdderReset); end
      checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready_rel got=%b exp=1", InReady); end
   endtask

   task automatic test_basic;
      int w, lat;
      OutReady = 1'b1;
      offer(32'h3F800000, 32'h3F800000, w);
      checks++; if (w !== 0) begin failures++; $display("FAIL basic_accept waited=%0d exp=0", w); end
      checks++; if (Go !== 1'b1) begin failures++; $display("FAIL basic_go_high got=%b exp=1", Go); end
      checks++; if (AddendA !== 32'h3F800000 || AddendB !== 32'h3F800000) begin failures++; $display("FAIL basic_addends got=%h/%h exp=3f800000/3f800000", AddendA, AddendB); end
      @(negedge Clock);
      checks++; if (Go !== 1'b0) begin failures++; $display("FAIL basic_go_low got=%b exp=0", Go); end
      lat = 1;
      while (!OutValid && lat < 50) begin
         @(negedge Clock);
         lat++;
      end
      checks++; if (lat !== 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
      checks++; if (OutResult !== 32'h40000000) begin failures++; $display("FAIL basic_result got=%h exp=40000000", OutResult); end
      checks++; if ({OutZero, OutInf, OutNan} !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", {OutZero, OutInf, OutNan}); end
      @(negedge Clock);
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%b exp=0", OutValid); end
   endtask

   task automatic test_back_to_back;
      int w, lat;
      OutReady = 1'b0;
      offer(32'h3F800000, 32'hBF800000, w);
      lat = 0;
      while (!OutValid && lat < 50) begin @(negedge Clock); lat++; end
      checks++; if (lat !== 6) begin failures++; $display("FAIL cancel_latency got=%0d exp=6", lat); end
      checks++; if (OutResult !== 32'h0 || OutZero !== 1'b1) begin failures++; $display("FAIL cancel_result got=%h z=%b exp=00000000 z=1", OutResult, OutZero); end
      pop1();
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL cancel_popped got=%b exp=0", OutValid); end
      offer(32'h3FC00000, 32'h40200000, w);
      checks++; if (stubReady !== 1'b1) begin failures++; $display("FAIL b2b_stale_ready got=%b exp=1", stubReady); end
      lat = 0;
      while (!OutValid && lat < 50) begin @(negedge Clock); lat++; end
      checks++; if (lat !== 6) begin failures++; $display("FAIL b2b_latency got=%0d exp=6", lat); end
      checks++; if (OutResult !== 32'h40800000 || OutZero !== 1'b0) begin failures++; $display("FAIL b2b_result got=%h z=%b exp=40800000 z=0", OutResult, OutZero); end
      pop1();
      offer(32'h7F800000, 32'h3F800000, w);
      lat = 0;
      while (!OutValid && lat < 50) begin @(negedge Clock); lat++; end
      checks++; if (OutResult !== 32'h7F800000 || OutInf !== 1'b1) begin failures++; $display("FAIL inf_result got=%h inf=%b exp=7f800000 inf=1", OutResult, OutInf); end
      pop1();
   endtask

   task automatic test_backpressure;
      int w, w4, w5;
      OutReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(bpA[i], bpB[i], w);
         checks++; if (w >= 200) begin failures++; $display("FAIL bp_accept%0d waited=%0d exp<200", i, w); end
      end
      InValid = 1'b1;
      InA = bpA[4];
      InB = bpB[4];
      repeat (10) @(negedge Clock);
      checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL bp_full_inready got=%b exp=0", InReady); end
      checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", dut.count); end
      checks++; if (OutValid !== 1'b1 || OutResult !== bpR[0]) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/%h", OutValid, OutResult, bpR[0]); end
      OutReady = 1'b1;
      fork
         begin
            offer(bpA[4], bpB[4], w4);
            offer(bpA[5], bpB[5], w5);
         end
         begin
            for (int i = 0; i < 6; i++) begin
               int t;
               t = 0;
               while (!OutValid && t < 100) begin @(negedge Clock); t++; end
               checks++; if (OutValid !== 1'b1 || OutResult !== bpR[i]) begin failures++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, OutValid, OutResult, bpR[i]); end
               @(negedge Clock);
            end
         end
      join
      checks++; if (w4 >= 200 || w5 >= 200) begin failures++; $display("FAIL bp_late_accept waited=%0d/%0d exp<200", w4, w5); end
   endtask

   task automatic test_push_pop;
      int w, t;
      OutReady = 1'b0;
      offer(32'h3F800000, 32'h3F800000, w);
      repeat (7) @(negedge Clock);
      offer(32'h3F800000, 32'h40000000, w);
      t = 0;
      while (stubReady && t < 50) begin @(negedge Clock); t++; end
      while (!stubReady && t < 50) begin @(negedge Clock); t++; end
      checks++; if (t >= 50) begin failures++; $display("FAIL pp_ready_wait cycles=%0d exp<50", t); end
      OutReady = 1'b1;
      @(negedge Clock);
      OutReady = 1'b0;
      checks++; if (dut.count !== 3'd1) begin failures++; $display("FAIL pp_count got=%0d exp=1", dut.count); end
      checks++; if (OutValid !== 1'b1 || OutResult !== 32'h40400000) begin failures++; $display("FAIL pp_head got=%b/%h exp=1/40400000", OutValid, OutResult); end
      pop1();
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", OutValid); end
   endtask

   task automatic test_watchdog;
      int w;
      OutReady = 1'b1;
      stubDead = 1'b1;
      offer(32'h3F800000, 32'h3F800000, w);
      repeat (63) @(negedge Clock);
      checks++; if (Timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%b exp=0", Timeout); end
      @(negedge Clock);
      checks++; if (Timeout !== 1'b1) begin failures++; $display("FAIL wd_fire got=%b exp=1", Timeout); end
      checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin failures++; $display("FAIL wd_idle inready=%b outvalid=%b exp=1/0", InReady, OutValid); end
      stubDead = 1'b0;
      repeat (3) @(negedge Clock);
      checks++; if (Timeout !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", Timeout); end
   endtask

   task automatic test_reset_midop;
      int w, lat;
      OutReady = 1'b0;
      offer(32'h3F800000, 32'h3F800000, w);
      repeat (7) @(negedge Clock);
      offer(32'h40000000, 32'h40000000, w);
      repeat (7) @(negedge Clock);
      offer(32'h40000000, 32'h40800000, w);
      repeat (4) @(negedge Clock);
      checks++; if (OutValid !== 1'b1 || dut.count !== 3'd2) begin failures++; $display("FAIL mid_queued got=%b/%0d exp=1/2", OutValid, dut.count); end
      ResetN = 1'b0;
      #1;
      checks++; if (OutValid !== 1'b0 || Go !== 1'b0) begin failures++; $display("FAIL mid_outputs outvalid=%b go=%b exp=0/0", OutValid, Go); end
      checks++; if (AdderReset !== 1'b1 || Timeout !== 1'b0) begin failures++; $display("FAIL mid_reset adderreset=%b timeout=%b exp=1/0", AdderReset, Timeout); end
      @(negedge Clock);
      ResetN = 1'b1;
      @(negedge Clock);
      checks++; if (AdderReset !== 1'b1) begin failures++; $display("FAIL mid_sync1 got=%b exp=1", AdderReset); end
      @(negedge Clock);
      checks++; if (AdderReset !== 1'b0) begin failures++; $display("FAIL mid_sync2 got=%b exp=0", AdderReset); end
      OutReady = 1'b1;
      offer(32'h3FC00000, 32'h40200000, w);
      lat = 0;
      while (!OutValid && lat < 50) begin @(negedge Clock); lat++; end
      checks++; if (lat !== 6 || OutResult !== 32'h40800000) begin failures++; $display("FAIL mid_next_op lat=%0d res=%h exp=6/40800000", lat, OutResult); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_push_pop();
      test_watchdog();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "bench timed out");
   end
endmodule
